// File: rtl/tt_um_unsigned_multiplier.sv
// -----------------------------------------------------------------------------
// tt_um_unsigned_multiplier
// 8x8 unsigned shift-add multiplier with a 16-bit registered product.
//
// Operands are loaded byte by byte through ui_in under control of uio_in.
// A rising edge on start latches the operands into working registers and runs
// eight shift-add steps, one per enabled clock. The finished accumulator is
// then copied into P in a single write, so P never shows a partial result.
//
// Handshake: start is edge-triggered and acts only in IDLE or DONE. busy is
// high for the whole RUN phase. done rises on the edge that writes P and stays
// high until the next accepted start edge. ena=0 freezes every register.
// -----------------------------------------------------------------------------
module tt_um_unsigned_multiplier (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic [7:0] ui_in,
   input  logic [7:0] uio_in,
   output logic [7:0] uo_out,
   output logic [7:0] uio_out,
   output logic [7:0] uio_oe
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Control decode from the bidirectional input byte
   logic load_a;
   logic load_b;
   logic start;
   logic sel_hi;

   assign load_a = uio_in[0];
   assign load_b = uio_in[1];
   assign start  = uio_in[2];
   assign sel_hi = uio_in[3];

   // Upper control bits carry no function
   logic unused_uio_hi;
   assign unused_uio_hi = ^uio_in[7:4];

   // Architectural state
   state_t      state_q;
   logic [7:0]  a_q;
   logic [7:0]  b_q;
   logic [15:0] p_q;
   logic [15:0] acc_q;
   logic [2:0]  cnt_q;
   logic        start_q;
   logic [15:0] mcand_q;   // working multiplicand, shifts left each step
   logic [7:0]  mplier_q;  // working multiplier, shifts right each step
   logic        busy_q;
   logic        done_q;

   // Next-value helpers used by the sequential block
   logic        idle_or_done;
   logic        start_edge;
   logic [7:0]  a_d;
   logic [7:0]  b_d;
   logic [15:0] acc_d;
   logic        last_step;

   assign idle_or_done = (state_q == IDLE) || (state_q == DONE);

   // A held-high start only counts in the cycle it first goes high
   assign start_edge = start && !start_q;

   // Operand values after this cycle's loads; a start in the same cycle sees
   // the freshly loaded byte
   always_comb begin
      a_d = a_q;
      b_d = b_q;
      if (idle_or_done) begin
         if (load_a) a_d = ui_in;
         if (load_b) b_d = ui_in;
      end
   end

   // One shift-add step: add the multiplicand when the multiplier LSB is set
   always_comb begin
      acc_d = acc_q;
      if (mplier_q[0]) acc_d = acc_q + mcand_q;
   end

   assign last_step = (cnt_q == 3'd7);

   // Control FSM and datapath registers; ena=0 holds everything
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         a_q      <= 8'h00;
         b_q      <= 8'h00;
         p_q      <= 16'h0000;
         acc_q    <= 16'h0000;
         cnt_q    <= 3'd0;
         start_q  <= 1'b0;
         mcand_q  <= 16'h0000;
         mplier_q <= 8'h00;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else if (ena) begin
         start_q <= start;
         case (state_q)
            IDLE, DONE: begin
               a_q <= a_d;
               b_q <= b_d;
               if (start_edge) begin
                  mcand_q  <= {8'h00, a_d};
                  mplier_q <= b_d;
                  acc_q    <= 16'h0000;
                  cnt_q    <= 3'd0;
                  state_q  <= RUN;
                  busy_q   <= 1'b1;
                  done_q   <= 1'b0;
               end
            end
            RUN: begin
               acc_q    <= acc_d;
               mcand_q  <= mcand_q << 1;
               mplier_q <= mplier_q >> 1;
               cnt_q    <= cnt_q + 3'd1;
               if (last_step) begin
                  p_q     <= acc_d;
                  state_q <= DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   // Status flags come from the committed product only
   logic ovf;
   logic zero;

   assign ovf  = (p_q[15:8] != 8'h00);
   assign zero = (p_q == 16'h0000);

   assign uo_out  = sel_hi ? p_q[15:8] : p_q[7:0];
   assign uio_out = {zero, ovf, done_q, busy_q, 4'b0000};
   assign uio_oe  = 8'hF0;

endmodule

// File: tb/tb_tt_um_unsigned_multiplier.sv
// -----------------------------------------------------------------------------
// Bench for tt_um_unsigned_multiplier.
// Driver tasks push the hand-computed product and expected busy length into
// queues; a monitor on the falling edge pops and compares whenever done rises.
// -----------------------------------------------------------------------------
module tb_tt_um_unsigned_multiplier;

   // ---------------- clock / reset ----------------
   logic       clk = 1'b0;
   logic       rst_n;
   logic       ena;
   logic [7:0] ui_in;
   logic [7:0] uio_in;
   logic [7:0] uo_out;
   logic [7:0] uio_out;
   logic [7:0] uio_oe;

   always #5 clk = ~clk;

   tt_um_unsigned_multiplier dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .ena     (ena),
      .ui_in   (ui_in),
      .uio_in  (uio_in),
      .uo_out  (uo_out),
      .uio_out (uio_out),
      .uio_oe  (uio_oe)
   );

   wire busy = uio_out[4];
   wire done = uio_out[5];
   wire ovf  = uio_out[6];
   wire zero = uio_out[7];

   // ---------------- scoreboard state ----------------
   logic [15:0] exp_q[$];
   int          lat_q[$];
   int          n_checks = 0;
   int          n_errors = 0;

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // ---------------- monitor ----------------
   logic busy_prev = 1'b0;
   logic done_prev = 1'b0;
   int   busy_cnt  = 0;

   always @(negedge clk) begin
      if (rst_n) begin
         if (busy && !busy_prev) busy_cnt = 1;
         else if (busy) busy_cnt++;
         if (done && !done_prev) begin
            if (exp_q.size() == 0) begin
               check("unexpected_done", 16'd1, 16'd0);
            end else begin
               logic [15:0] e;
               int          l;
               e = exp_q.pop_front();
               l = lat_q.pop_front();
               check("p_lo", {8'h00, uo_out}, {8'h00, e[7:0]});
               check("ovf", {15'd0, ovf}, {15'd0, (e[15:8] != 8'h00)});
               check("zero", {15'd0, zero}, {15'd0, (e == 16'h0000)});
               check("busy_cycles", busy_cnt[15:0], l[15:0]);
            end
         end
      end
      busy_prev = busy;
      done_prev = done;
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load_ab(input logic [7:0] a, input logic [7:0] b);
      ui_in = a; uio_in[0] = 1'b1;
      tick();
      uio_in[0] = 1'b0;
      ui_in = b; uio_in[1] = 1'b1;
      tick();
      uio_in[1] = 1'b0;
   endtask

   task automatic pulse_start();
      uio_in[2] = 1'b1;
      tick();
      uio_in[2] = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      int n;
      n = 0;
      while (!(done && !busy) && n < budget) begin
         tick();
         n++;
      end
      if (!(done && !busy)) check("done_timeout", 16'd0, 16'd1);
   endtask

   // After done, look at the upper byte through the output mux
   task automatic check_hi(input logic [15:0] p);
      uio_in[3] = 1'b1;
      #1;
      check("p_hi", {8'h00, uo_out}, {8'h00, p[15:8]});
      uio_in[3] = 1'b0;
      #1;
   endtask

   task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [15:0] p);
      load_ab(a, b);
      exp_q.push_back(p);
      lat_q.push_back(8);
      pulse_start();
      wait_done(40);
      check_hi(p);
   endtask

   // ---------------- directed vectors ----------------
   typedef struct {
      logic [7:0]  a;
      logic [7:0]  b;
      logic [15:0] p;
   } vec_t;

   vec_t vecs[9];

   initial begin
      vecs[0] = '{8'd100, 8'd5,   16'h01F4};
      vecs[1] = '{8'd25,  8'd5,   16'h007D};
      vecs[2] = '{8'd50,  8'd10,  16'h01F4};
      vecs[3] = '{8'd255, 8'd255, 16'hFE01};
      vecs[4] = '{8'd0,   8'd77,  16'h0000};
      vecs[5] = '{8'd13,  8'd11,  16'h008F};
      vecs[6] = '{8'd1,   8'd255, 16'h00FF};
      vecs[7] = '{8'd128, 8'd2,   16'h0100};
      vecs[8] = '{8'd200, 8'd200, 16'h9C40};
   end

   // ---------------- main sequence ----------------
   initial begin
      rst_n  = 1'b0;
      ena    = 1'b1;
      ui_in  = 8'h00;
      uio_in = 8'h00;
      repeat (3) tick();
      rst_n = 1'b1;
      tick();

      // reset state
      check("rst_uo_out", {8'h00, uo_out}, 16'h0000);
      check("rst_uio_out", {8'h00, uio_out}, 16'h0080);
      check("rst_uio_oe", {8'h00, uio_oe}, 16'h00F0);

      // main function
      foreach (vecs[i]) run_op(vecs[i].a, vecs[i].b, vecs[i].p);

      // start held high for 20 cycles: one computation only
      load_ab(8'd7, 8'd9);
      exp_q.push_back(16'h003F);
      lat_q.push_back(8);
      uio_in[2] = 1'b1;
      repeat (20) tick();
      uio_in[2] = 1'b0;
      check("held_start_done", {15'd0, done}, 16'd1);
      check("held_start_busy", {15'd0, busy}, 16'd0);
      check_hi(16'h003F);

      // second start edge at RUN cycle 3 is ignored
      load_ab(8'd12, 8'd12);
      exp_q.push_back(16'h0090);
      lat_q.push_back(8);
      pulse_start();
      tick();
      pulse_start();
      wait_done(40);
      check_hi(16'h0090);

      // loads during RUN are ignored; old result stays visible meanwhile
      load_ab(8'd20, 8'd30);
      exp_q.push_back(16'h0258);
      lat_q.push_back(8);
      pulse_start();
      check("p_held_in_run", {8'h00, uo_out}, 16'h0090);
      ui_in = 8'd99; uio_in[0] = 1'b1;
      tick();
      uio_in[0] = 1'b0;
      ui_in = 8'd77; uio_in[1] = 1'b1;
      tick();
      uio_in[1] = 1'b0;
      wait_done(40);
      check_hi(16'h0258);

      // load and start in the same cycle: new A=6 used with B=30
      exp_q.push_back(16'h00B4);
      lat_q.push_back(8);
      ui_in = 8'd6;
      uio_in[0] = 1'b1;
      uio_in[2] = 1'b1;
      tick();
      uio_in[0] = 1'b0;
      uio_in[2] = 1'b0;
      wait_done(40);
      check_hi(16'h00B4);

      // reset at RUN cycle 4 aborts with no partial product
      load_ab(8'd100, 8'd5);
      pulse_start();
      repeat (3) tick();
      rst_n = 1'b0;
      tick();
      check("abort_busy", {15'd0, busy}, 16'd0);
      check("abort_done", {15'd0, done}, 16'd0);
      check("abort_zero", {15'd0, zero}, 16'd1);
      check("abort_p_lo", {8'h00, uo_out}, 16'h0000);
      check_hi(16'h0000);
      rst_n = 1'b1;
      tick();

      // ena=0 for 5 cycles mid-RUN delays done by 5 cycles
      load_ab(8'd25, 8'd5);
      exp_q.push_back(16'h007D);
      lat_q.push_back(13);
      pulse_start();
      repeat (2) tick();
      ena = 1'b0;
      repeat (5) tick();
      check("paused_busy", {15'd0, busy}, 16'd1);
      ena = 1'b1;
      wait_done(40);
      check_hi(16'h007D);

      // drain and report
      repeat (4) tick();
      check("outstanding", exp_q.size(), 16'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   // hard time limit
   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/tt_um_unsigned_multiplier.md
TT_UM_UNSIGNED_MULTIPLIER -- requirements
Module: tt_um_unsigned_multiplier

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-003 SHALL have port ena, input, 1 bit: ena=0 holds all state (no loads, no FSM advance); outputs keep their values.
REQ-004 SHALL have port ui_in, input, 8 bits: operand data byte.
REQ-005 SHALL have port uio_in, input, 8 bits: [0] load_a, [1] load_b, [2] start, [3] sel_hi; [7:4] ignored.
REQ-006 SHALL have port uo_out, output, 8 bits: product byte; sel_hi=0 gives P[7:0], sel_hi=1 gives P[15:8] (combinational mux of the registered product).
REQ-007 SHALL have port uio_out, output, 8 bits: [4] busy, [5] done, [6] ovf (P[15:8]!=0), [7] zero (P==0); [3:0] driven 0.
REQ-008 SHALL have port uio_oe, output, 8 bits: constant 8'hF0.

Function
REQ-009 SHALL hold 8-bit operand registers A and B, a 16-bit product register P, a 16-bit accumulator, a 3-bit step counter, a registered copy of start, and a 2-bit FSM {IDLE, RUN, DONE}.
REQ-010 SHALL, in IDLE or DONE with ena=1, load A<=ui_in when load_a=1 and B<=ui_in when load_b=1; if both are high, load both with the same byte.
REQ-011 SHALL ignore load_a and load_b while in RUN.
REQ-012 SHALL detect start as a rising edge: start=1 in the current cycle and start_q=0; a held-high start triggers once.
REQ-013 SHALL, on a start edge in IDLE or DONE, clear the accumulator and counter, latch A and B into working registers, and enter RUN; a load in the same cycle is applied first, so the new byte is used.
REQ-014 SHALL, in RUN, perform one shift-add step per enabled cycle: if the multiplier LSB is 1, add the shifted multiplicand to the accumulator; then shift the multiplicand left and the multiplier right.
REQ-015 SHALL spend exactly 8 enabled cycles in RUN, then copy the accumulator into P and enter DONE on the edge that completes step 8.
REQ-016 SHALL compute P as the full unsigned 16-bit product A*B with no truncation; the maximum is 255*255 = 16'hFE01.
REQ-017 SHALL drive busy=1 exactly while the FSM is in RUN.
REQ-018 SHALL drive done=1 exactly while the FSM is in DONE; DONE persists until the next start edge, which returns done to 0 and enters RUN.
REQ-019 SHALL ignore a start edge while in RUN (no restart, no queuing).
REQ-020 SHALL leave P unchanged during RUN; uo_out, ovf and zero keep showing the previous result until the new result is written.
REQ-021 SHALL derive ovf and zero from P only.
REQ-022 SHALL, with ena=0 mid-RUN, pause the step count and resume where it stopped when ena returns; the total of enabled RUN cycles stays 8.

Reset
REQ-023 SHALL, while rst_n=0 at a clock edge, set FSM=IDLE and clear A, B, P, the accumulator, the counter and start_q to 0.
REQ-024 SHALL drive uo_out=0, busy=0, done=0, ovf=0, zero=1 and uio_oe=8'hF0 after reset.
REQ-025 SHALL abort any RUN in progress on reset, with no partial product written to P.

Verification
REQ-026 SHALL cover this case: load A=100, B=5, pulse start -> busy for 8 cycles, then done=1, P=16'h01F4, uo_out=F4 (sel_hi=0) and 01 (sel_hi=1), ovf=1, zero=0.
REQ-027 SHALL cover this case: A=25, B=5 -> P=16'h007D, ovf=0, zero=0; A=50, B=10 -> P=16'h01F4.
REQ-028 SHALL cover this case: A=255, B=255 -> P=16'hFE01, ovf=1; A=0, B=77 -> P=0, zero=1.
REQ-029 SHALL cover this case: start held high for 20 cycles -> exactly one computation; a start edge at RUN cycle 3 is ignored and done still appears after 8 cycles.
REQ-030 SHALL cover this case: load_a/load_b with new bytes during RUN -> ignored, so the result uses the original operands.
REQ-031 SHALL cover this case: rst_n=0 at RUN cycle 4 -> next cycle IDLE, busy=0, done=0, P=0; ena=0 for 5 cycles mid-RUN -> done is delayed by 5 cycles and the product is correct.
